// File: rtl/net_router_flattened.sv
// net_router_flattened: per-input FIFOs, per-output round-robin arbiters and registered outputs.
// Define NET_ROUTER_DROP_CNT_EN to add the saturating drop_count_o port and counter.
module net_router_flattened #(
    parameter int NUM_CH_P     = 4,
    parameter int PKT_WIDTH_P  = 32,
    parameter int DEST_LSB_P   = 0,
    parameter int DEST_WIDTH_P = 2,
    parameter int FIFO_DEPTH_P = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_CH_P*PKT_WIDTH_P-1:0] in_data_flat_i,
    input  logic [NUM_CH_P-1:0]             in_valid_i,
    output logic [NUM_CH_P-1:0]             in_ready_o,
    output logic [NUM_CH_P*PKT_WIDTH_P-1:0] out_data_flat_o,
    output logic [NUM_CH_P-1:0]             out_valid_o,
    input  logic [NUM_CH_P-1:0]             out_ready_i
`ifdef NET_ROUTER_DROP_CNT_EN
   ,output logic [15:0]                     drop_count_o
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH_P);
    localparam int PW = (NUM_CH_P > 1) ? $clog2(NUM_CH_P) : 1;

    typedef logic [PKT_WIDTH_P-1:0] pkt_t;

    pkt_t                  mem_q      [NUM_CH_P][FIFO_DEPTH_P];
    pkt_t                  mem_d      [NUM_CH_P][FIFO_DEPTH_P];
    logic [AW-1:0]         rd_ptr_q   [NUM_CH_P];
    logic [AW-1:0]         rd_ptr_d   [NUM_CH_P];
    logic [AW-1:0]         wr_ptr_q   [NUM_CH_P];
    logic [AW-1:0]         wr_ptr_d   [NUM_CH_P];
    logic [AW:0]           count_q    [NUM_CH_P];
    logic [AW:0]           count_d    [NUM_CH_P];
    logic [PW-1:0]         arb_ptr_q  [NUM_CH_P];
    logic [PW-1:0]         arb_ptr_d  [NUM_CH_P];
    pkt_t                  out_data_q [NUM_CH_P];
    pkt_t                  out_data_d [NUM_CH_P];
    logic [NUM_CH_P-1:0]   out_valid_q, out_valid_d;
    logic                  init_done_q, init_done_d;

    pkt_t                  head_pkt   [NUM_CH_P];
    logic [DEST_WIDTH_P-1:0] head_dest [NUM_CH_P];
    logic [NUM_CH_P-1:0]   head_vld, drop, pop, push, granted;

    // Ready stays low until the first edge after reset has been seen.
    always_comb begin
        in_ready_o = '0;
        for (int unsigned c = 0; c < NUM_CH_P; c++) begin
            in_ready_o[c] = init_done_q && (count_q[c] != (AW+1)'(FIFO_DEPTH_P));
        end
    end

    always_comb begin
        mem_d       = mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        arb_ptr_d   = arb_ptr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q & ~out_ready_i;
        init_done_d = 1'b1;
        head_vld    = '0;
        drop        = '0;
        push        = '0;
        granted     = '0;

        for (int unsigned c = 0; c < NUM_CH_P; c++) begin
            head_pkt[c]  = mem_q[c][rd_ptr_q[c]];
            head_dest[c] = head_pkt[c][DEST_LSB_P +: DEST_WIDTH_P];
            head_vld[c]  = (count_q[c] != '0);
            drop[c]      = head_vld[c] && (32'(head_dest[c]) >= 32'(NUM_CH_P));
        end
        pop = drop;

        // Scan inputs starting at the pointer; the first requester wins.
        for (int unsigned d = 0; d < NUM_CH_P; d++) begin
            if (!out_valid_q[d] || out_ready_i[d]) begin
                for (int unsigned k = 0; k < NUM_CH_P; k++) begin
                    for (int unsigned i = 0; i < NUM_CH_P; i++) begin
                        if (!granted[d] && head_vld[i] && (32'(head_dest[i]) == d) &&
                            (i == (32'(arb_ptr_q[d]) + k) % NUM_CH_P)) begin
                            granted[d]     = 1'b1;
                            pop[i]         = 1'b1;
                            out_valid_d[d] = 1'b1;
                            out_data_d[d]  = head_pkt[i];
                            arb_ptr_d[d]   = PW'((i + 1) % NUM_CH_P);
                        end
                    end
                end
            end
        end

        for (int unsigned c = 0; c < NUM_CH_P; c++) begin
            push[c] = in_valid_i[c] && in_ready_o[c];
            if (push[c]) begin
                mem_d[c][wr_ptr_q[c]] = in_data_flat_i[c*PKT_WIDTH_P +: PKT_WIDTH_P];
                wr_ptr_d[c]           = wr_ptr_q[c] + AW'(1);
            end
            if (pop[c]) begin
                rd_ptr_d[c] = rd_ptr_q[c] + AW'(1);
            end
            case ({push[c], pop[c]})
                2'b10:   count_d[c] = count_q[c] + (AW+1)'(1);
                2'b01:   count_d[c] = count_q[c] - (AW+1)'(1);
                default: count_d[c] = count_q[c];
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned c = 0; c < NUM_CH_P; c++) begin
                for (int unsigned e = 0; e < FIFO_DEPTH_P; e++) begin
                    mem_q[c][e] <= '0;
                end
                rd_ptr_q[c]   <= '0;
                wr_ptr_q[c]   <= '0;
                count_q[c]    <= '0;
                arb_ptr_q[c]  <= '0;
                out_data_q[c] <= '0;
            end
            out_valid_q <= '0;
            init_done_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            arb_ptr_q   <= arb_ptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        out_data_flat_o = '0;
        for (int unsigned d = 0; d < NUM_CH_P; d++) begin
            out_data_flat_o[d*PKT_WIDTH_P +: PKT_WIDTH_P] = out_data_q[d];
        end
        out_valid_o = out_valid_q;
    end

`ifdef NET_ROUTER_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [16:0] drop_sum;

    always_comb begin
        drop_sum = {1'b0, drop_cnt_q};
        for (int unsigned c = 0; c < NUM_CH_P; c++) begin
            drop_sum = drop_sum + 17'(drop[c]);
        end
        drop_cnt_d = drop_sum[16] ? '1 : drop_sum[15:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_net_router_flattened.sv
// Bench for net_router_flattened: directed scenarios on a 4- and a 3-channel instance, plus a
// randomized run scored against per-(source,destination) FIFO-order queues.
module tb_net_router_flattened;
    localparam int N  = 4;
    localparam int N3 = 3;
    localparam int W  = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [N*W-1:0]  in_data, out_data;
    logic [N-1:0]    in_valid, in_ready, out_valid, out_ready;
    logic [N3*W-1:0] in_data3, out_data3;
    logic [N3-1:0]   in_valid3, in_ready3, out_valid3, out_ready3;
`ifdef NET_ROUTER_DROP_CNT_EN
    logic [15:0]     drop_cnt, drop_cnt3;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0]     exp_q [N*N][$];
    logic [31:0]     pkt, expv;
    logic [31:0]     prev_data [N];
    logic [N-1:0]    prev_stall, saw;
    logic [N3-1:0]   saw3;
    logic            acc;
    int              sent, qi, remaining, model_drops;
    int              exp_src [9] = '{0, 1, 3, 0, 1, 3, 0, 1, 3};

    always #5 clk = ~clk;

    net_router_flattened dut (
        .clk            (clk),
        .reset          (reset),
        .in_data_flat_i (in_data),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .out_data_flat_o(out_data),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready)
`ifdef NET_ROUTER_DROP_CNT_EN
       ,.drop_count_o   (drop_cnt)
`endif
    );

    net_router_flattened #(.NUM_CH_P(N3)) dut3 (
        .clk            (clk),
        .reset          (reset),
        .in_data_flat_i (in_data3),
        .in_valid_i     (in_valid3),
        .in_ready_o     (in_ready3),
        .out_data_flat_o(out_data3),
        .out_valid_o    (out_valid3),
        .out_ready_i    (out_ready3)
`ifdef NET_ROUTER_DROP_CNT_EN
       ,.drop_count_o   (drop_cnt3)
`endif
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expd);
        checks++;
        assert (obs === expd) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expd);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packet layout: [31:4] sequence tag, [3:2] source channel, [1:0] destination.
    function automatic logic [31:0] mk(input int src, input int dst, input int seq);
        logic [31:0] p;
        p      = 32'(seq) << 4;
        p[3:2] = src[1:0];
        p[1:0] = dst[1:0];
        return p;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        in_data    = '0;
        in_valid   = '0;
        out_ready  = '1;
        in_data3   = '0;
        in_valid3  = '0;
        out_ready3 = '1;
        prev_stall = '0;
        #2;
        check("rst_out_valid", 128'(out_valid), 128'h0);
        check("rst_out_data", 128'(out_data), 128'h0);
        check("rst_in_ready", 128'(in_ready), 128'h0);
        check("rst_out_valid3", 128'(out_valid3), 128'h0);
        check("rst_in_ready3", 128'(in_ready3), 128'h0);
`ifdef NET_ROUTER_DROP_CNT_EN
        check("rst_drop_cnt3", 128'(drop_cnt3), 128'h0);
`endif
        tick();
        tick();
        reset = 1'b0;
        check("ready_first_edge", 128'(in_ready), 128'h0);
        tick();
        check("ready_after_init", 128'(in_ready), 128'hF);

        // Single packet ch0 -> dest 2, two-edge latency
        in_data[0 +: W] = 32'h0000_0002;
        in_valid        = 4'b0001;
        tick();
        in_valid = '0;
        check("lat_edge_k", 128'(out_valid), 128'h0);
        tick();
        check("lat_valid", 128'(out_valid), 128'h4);
        check("lat_data", 128'(out_data[2*W +: W]), 128'h2);
        tick();
        check("lat_drained", 128'(out_valid), 128'h0);

        // Round-robin: ch0, ch1, ch3 each send 3 packets to dest 1
        for (int i = 0; i < 11; i++) begin
            if (i < 3) begin
                in_valid = 4'b1011;
                in_data[0*W +: W] = mk(0, 1, i);
                in_data[1*W +: W] = mk(1, 1, i);
                in_data[3*W +: W] = mk(3, 1, i);
                check("rr_ready", 128'(in_ready & 4'b1011), 128'hB);
            end else begin
                in_valid = '0;
            end
            tick();
            if (i >= 1 && i <= 9) begin
                check("rr_valid", 128'(out_valid), 128'h2);
                check("rr_data", 128'(out_data[W +: W]), 128'(mk(exp_src[i-1], 1, (i-1)/3)));
            end
        end
        check("rr_done", 128'(out_valid), 128'h0);

        // Backpressure on output 2 while ch1 offers 6 packets
        out_ready = 4'b1011;
        sent      = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid           = (sent < 6) ? 4'b0010 : 4'b0000;
            in_data[W +: W]    = mk(1, 2, sent);
            acc                = in_valid[1] && in_ready[1];
            tick();
            if (acc) sent++;
        end
        in_valid = '0;
        check("bp_accepted", 128'(sent), 128'd5);
        check("bp_ready_low", 128'(in_ready[1]), 128'h0);
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_valid", 128'(out_valid), 128'h4);
            check("bp_hold_data", 128'(out_data[2*W +: W]), 128'(mk(1, 2, 0)));
            if (i < 2) tick();
        end
        out_ready = '1;
        for (int j = 1; j < 5; j++) begin
            tick();
            check("bp_drain_valid", 128'(out_valid), 128'h4);
            check("bp_drain_data", 128'(out_data[2*W +: W]), 128'(mk(1, 2, j)));
        end
        tick();
        check("bp_drain_done", 128'(out_valid), 128'h0);
        check("bp_ready_back", 128'(in_ready), 128'hF);

        // Reset with packets buffered
        out_ready = 4'b1110;
        for (int i = 0; i < 2; i++) begin
            in_valid          = 4'b0100;
            in_data[2*W +: W] = mk(2, 0, i);
            tick();
        end
        in_valid = '0;
        tick();
        check("pre_rst_valid", 128'(out_valid), 128'h1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 128'(out_valid), 128'h0);
        check("mid_rst_ready", 128'(in_ready), 128'h0);
        check("mid_rst_data", 128'(out_data), 128'h0);
        tick();
        reset     = 1'b0;
        out_ready = '1;
        check("post_rst_ready_first", 128'(in_ready), 128'h0);
        saw = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            saw |= out_valid;
        end
        check("post_rst_no_stale", 128'(saw), 128'h0);
        check("post_rst_ready", 128'(in_ready), 128'hF);

        // Randomized traffic, then drain with all outputs ready
        for (int cyc = 0; cyc < 2040; cyc++) begin
            for (int d = 0; d < N; d++) begin
                if (prev_stall[d]) begin
                    check("hold_valid", 128'(out_valid[d]), 128'h1);
                    check("hold_data", 128'(out_data[d*W +: W]), 128'(prev_data[d]));
                end
            end
            for (int c = 0; c < N; c++) begin
                in_valid[c]       = (cyc < 2000) && ($urandom_range(0, 9) < 6);
                in_data[c*W +: W] = mk(c, int'($urandom_range(0, 3)), int'($urandom));
                out_ready[c]      = (cyc >= 2000) || ($urandom_range(0, 9) < 7);
            end
            for (int c = 0; c < N; c++) begin
                if (in_valid[c] && in_ready[c]) begin
                    pkt = in_data[c*W +: W];
                    exp_q[c*N + int'(pkt[1:0])].push_back(pkt);
                end
            end
            for (int d = 0; d < N; d++) begin
                if (out_valid[d] && out_ready[d]) begin
                    pkt = out_data[d*W +: W];
                    check("rnd_dest", 128'(pkt[1:0]), 128'(d));
                    qi = int'(pkt[3:2]) * N + d;
                    check("rnd_expected", 128'(exp_q[qi].size() > 0), 128'h1);
                    if (exp_q[qi].size() > 0) begin
                        expv = exp_q[qi].pop_front();
                        check("rnd_order", 128'(pkt), 128'(expv));
                    end
                end
                prev_stall[d] = out_valid[d] && !out_ready[d];
                prev_data[d]  = out_data[d*W +: W];
            end
            tick();
        end
        remaining = 0;
        for (int q = 0; q < N*N; q++) remaining += exp_q[q].size();
        check("rnd_all_delivered", 128'(remaining), 128'h0);
        check("rnd_idle", 128'(out_valid), 128'h0);
`ifdef NET_ROUTER_DROP_CNT_EN
        check("rnd_no_drops", 128'(drop_cnt), 128'h0);
`endif

        // 3-channel instance: dest 3 is invalid and gets dropped
        in_data3[W +: W] = mk(1, 3, 0);
        in_valid3        = 3'b010;
        tick();
        in_valid3 = '0;
        saw3 = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            saw3 |= out_valid3;
        end
        check("drop_no_output", 128'(saw3), 128'h0);
`ifdef NET_ROUTER_DROP_CNT_EN
        check("drop_cnt_one", 128'(drop_cnt3), 128'h1);
`endif
        in_data3[W +: W] = mk(1, 0, 1);
        in_valid3        = 3'b010;
        tick();
        in_valid3 = '0;
        check("after_drop_lat", 128'(out_valid3), 128'h0);
        tick();
        check("after_drop_valid", 128'(out_valid3), 128'h1);
        check("after_drop_data", 128'(out_data3[0 +: W]), 128'(mk(1, 0, 1)));

`ifdef NET_ROUTER_DROP_CNT_EN
        // Flood with invalid destinations until the counter saturates
        model_drops = 1;
        saw3        = '0;
        for (int i = 0; i < 23000; i++) begin
            in_valid3 = (i < 200 || i > 202) ? 3'b111 : 3'b000;
            for (int c = 0; c < N3; c++) in_data3[c*W +: W] = mk(c, 3, i);
            model_drops += $countones(in_valid3 & in_ready3);
            tick();
            saw3 |= out_valid3;
            if (i == 202) begin
                check("drop_cnt_mid", 128'(drop_cnt3), 128'(model_drops));
            end
        end
        in_valid3 = '0;
        tick();
        tick();
        check("flood_model_past_sat", 128'(model_drops > 65535), 128'h1);
        check("drop_cnt_saturated", 128'(drop_cnt3), 128'hFFFF);
        check("flood_no_output", 128'(saw3), 128'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/net_router_flattened.md
NET_ROUTER_FLATTENED -- requirements
Module: net_router_flattened

Interface
REQ-001 SHALL have parameter NUM_CH_P, default 4, giving the number of network channels (core ports).
REQ-002 SHALL have parameter PKT_WIDTH_P, default 32, giving the packet width in bits.
REQ-003 SHALL have parameter DEST_LSB_P, default 0, giving the LSB of the destination-ID field within a packet.
REQ-004 SHALL have parameter DEST_WIDTH_P, default 2, giving the destination-ID width; 2**DEST_WIDTH_P >= NUM_CH_P is required.
REQ-005 SHALL have parameter FIFO_DEPTH_P, default 4, giving the per-input FIFO depth; it must be a power of two and >= 2.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-008 SHALL have port in_data_flat_i, input, NUM_CH_P*PKT_WIDTH_P bits; channel c occupies bits [c*PKT_WIDTH_P +: PKT_WIDTH_P].
REQ-009 SHALL have port in_valid_i, input, NUM_CH_P bits, per-channel input valid.
REQ-010 SHALL have port in_ready_o, output, NUM_CH_P bits, per-channel input ready.
REQ-011 SHALL have port out_data_flat_o, output, NUM_CH_P*PKT_WIDTH_P bits, using the same slicing as in_data_flat_i.
REQ-012 SHALL have port out_valid_o, output, NUM_CH_P bits, per-channel output valid.
REQ-013 SHALL have port out_ready_i, input, NUM_CH_P bits, per-channel output ready.
REQ-014 SHALL have port drop_count_o, output, 16 bits, the dropped-packet count; present only under NET_ROUTER_DROP_CNT_EN.

Function
REQ-015 SHALL accept a packet on channel c when in_valid_i[c] and in_ready_o[c] are both high at a rising edge, writing it to input FIFO c.
REQ-016 SHALL drive in_ready_o[c] high exactly when FIFO c holds fewer than FIFO_DEPTH_P entries; a pop in the same cycle does not raise ready while full.
REQ-017 SHALL take a head packet's destination as bits [DEST_LSB_P +: DEST_WIDTH_P]; a destination >= NUM_CH_P is invalid.
REQ-018 SHALL pop a head packet with an invalid destination at the next edge, forward it nowhere, and count it as dropped.
REQ-019 SHALL give each output d a round-robin arbiter over the input FIFO heads whose destination is d.
REQ-020 SHALL start arbiter priority at input (d's pointer); after a grant to input g, the pointer becomes (g+1) mod NUM_CH_P.
REQ-021 SHALL hold one output register per channel; a grant loads the register and pops the source FIFO at the same edge.
REQ-022 SHALL grant only when the output register is empty or out_ready_i[d] is high that cycle, giving bubble-free back-to-back transfers.
REQ-023 SHALL hold out_valid_o[d] and its data stable while out_ready_i[d] is low.
REQ-024 SHALL route a packet accepted into an empty FIFO at edge k so that out_valid_o is high after edge k+1 when uncontended; minimum latency is 2 edges.
REQ-025 SHALL route a packet whose destination equals its source channel like any other packet (loopback).
REQ-026 SHALL block a FIFO while its head loses arbitration or its destination output is stalled, with head-of-line blocking and no reordering within a channel.
REQ-027 SHALL deliver packets from one input to one output in acceptance order.

Reset
REQ-028 SHALL, while reset is high, empty all FIFOs, clear out_valid_o to 0, clear out_data_flat_o to 0, and set all arbiter pointers to 0.
REQ-029 SHALL hold in_ready_o at 0 while reset is high and for the first edge after deassertion, then drive it per REQ-016.
REQ-030 SHALL discard any packet in flight when reset asserts mid-operation; nothing it held is emitted after reset.

Configuration
REQ-031 SHALL, with NET_ROUTER_DROP_CNT_EN defined, provide drop_count_o, reset to 0, incrementing by the number of packets dropped per cycle and saturating at 16'hFFFF.
REQ-032 SHALL, without NET_ROUTER_DROP_CNT_EN, omit the port and counter while still dropping invalid-destination packets.

Verification
REQ-033 SHALL cover: ch0 sends 32'h0000_0002 with all out_ready_i high -> out_valid_o[2] high after edge k+1 with data 32'h0000_0002; no other output valid.
REQ-034 SHALL cover: ch0, ch1 and ch3 each send 3 packets to dest 1, all in the same cycle -> output 1 emits them in order ch0, ch1, ch3, ch0, ch1, ch3, ... on consecutive cycles.
REQ-035 SHALL cover: out_ready_i[2]=0 while ch1 sends 6 packets to dest 2 -> 1 packet held in the output register, 4 in the FIFO, in_ready_o[1]=0; releasing ready drains all 5 in order with no loss.
REQ-036 SHALL cover: NUM_CH_P=3, send a packet with dest 3 -> no out_valid_o; drop_count_o reads 1 (with macro), and subsequent packets on that channel route normally.
REQ-037 SHALL cover: assert reset with 2 packets buffered -> all out_valid_o are 0 and in_ready_o is 0 during reset; no stale packet appears after deassertion.
REQ-038 SHALL cover: preload drop_count_o to 16'hFFFF by stimulus, then drop one more packet -> drop_count_o stays 16'hFFFF.
